fb_vram: RTL
============

Name: fb_vram

Overview:
- Single-clock framebuffer that sits directly upstream of the VGA timing generator.
- Serves its pixel read requests (address in, 3-bit pixel out, 1-cycle latency).
- Accepts (x,y,color) pixel writes from a drawing engine over a valid/ready handshake; computes linear address y*width+x in a 2-stage pipeline.
- Provides a hardware full-screen clear sweep.

Parameters:
- BUF_WIDTH, 640, physical maximum line width in pixels.
- BUF_HEIGHT, 480, physical maximum line count.
- PIX_W, 3, bits per pixel (RGB, 1 bit each).
- ADDR_W, 20, linear address width; must satisfy 2**ADDR_W >= BUF_WIDTH*BUF_HEIGHT.

Ports:
- clk  in  1  single clock; the video clock when paired with the VGA generator.
- srst_n  in  1  reset: one clock; synchronous, active-low.
- width  in  10  runtime line stride / active width; must be <= BUF_WIDTH.
- height  in  10  runtime line count; must be <= BUF_HEIGHT.
- rd_addr  in  ADDR_W  pixel read address (VGA req_addr).
- rd_data  out  PIX_W  pixel read result (VGA pixel).
- visible  in  1  VGA active-area flag.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accept.
- wr_x  in  10  write column.
- wr_y  in  10  write row.
- wr_color  in  PIX_W  write pixel value.
- wr_oob  out  1  1-cycle pulse: accepted write dropped as out of bounds.
- clr_req  in  1  start clear.
- clr_color  in  PIX_W  clear value, sampled with clr_req.
- clr_busy  out  1  clear pending or in progress.
- clr_done  out  1  1-cycle pulse when clear finishes.

Behaviour:
- Storage: N = BUF_WIDTH*BUF_HEIGHT words of PIX_W.
  - Contents are NOT reset.
  - One write port and one read port; read-first on same-address collision.
- Reset (srst_n=0 at a clk edge):
  - rd_data=0, wr_ready=0, wr_oob=0, clr_busy=0, clr_done=0.
  - Pipeline valids cleared; FSM to IDLE.
  - Reset mid-clear or mid-write abandons the operation; no further memory writes.
  - wr_ready rises 1 cycle after srst_n returns high.
- Read path:
  - rd_data <= mem[rd_addr] registered, 1-cycle latency, every cycle, never stalled.
  - rd_addr >= N returns 0.
- Write handshake:
  - Transfer when wr_valid && wr_ready at an edge.
  - wr_ready = (state==IDLE) && srst_n, gated per Optional Feature.
  - Fully pipelined: one accepted write per cycle.
- Write pipeline:
  - S1 registers x, y, color and the bounds flag (x<width && y<height).
  - S2 registers addr = y*width + x (20-bit, no truncation) and the flag.
  - Memory write occurs at the S2 edge (accept edge E0, memory updated at E0+2). A read issued after E0+2 returns new data at E0+3.
  - Out-of-bounds writes: no memory write; wr_oob pulses in the S2 cycle.
- Clear FSM:
  - IDLE: clr_req=1 latches clr_color, sets clr_busy -> DRAIN.
  - DRAIN: wait until S1/S2 both empty -> SWEEP with ptr=0.
  - SWEEP: write clr_color to mem[ptr] each cycle, ptr++. When ptr == width*height-1 (product computed once on DRAIN exit), write the last word -> DONE.
  - DONE: clr_done=1 for one cycle, clr_busy=0 -> IDLE.
  - clr_req while not IDLE is ignored.
  - If clr_req and a write handshake occur in the same cycle, the write is accepted and the clear waits in DRAIN.
  - If width or height is 0 on DRAIN exit, skip SWEEP -> DONE.
- width/height changes mid-operation affect only subsequently accepted writes and clears.

Optional Feature:
- FB_TEARFREE_EN defined:
  - wr_ready is additionally forced low while visible=1.
  - SWEEP holds ptr and suppresses the write on any cycle with visible=1.
  - All memory updates therefore land during blanking.
- Undefined: visible is ignored; writes and sweep proceed every cycle (tearing possible).

Decomposition:
- Package fb_pkg:
  - PIX_W and ADDR_W defaults.
  - typedef pixel_t, addr_t.
  - enum fb_clr_state_e {IDLE, DRAIN, SWEEP, DONE}.
- Sub-module fb_wr_addr_pipe: 2-stage bounds check + address multiply pipeline, with valid propagation and flush on reset.
- Top holds the memory array, read port, clear FSM and ready logic.

Test Plan (BUF_WIDTH=8, BUF_HEIGHT=4, width=8, height=4):
- Write x=3,y=2,color=5, then read rd_addr=19 -> rd_data=5 exactly 1 cycle after address; accept-to-readable = E0+3.
- Write x=8,y=0 (x>=width) -> wr_oob pulses once 2 cycles after accept; mem[8] unchanged.
- clr_req with clr_color=2 while 2 writes in flight:
  - Writes land first, then 32 SWEEP cycles.
  - clr_done pulses once; all 32 reads return 2; wr_ready low for the whole busy interval.
- Back-to-back writes on 32 consecutive cycles -> wr_ready stays 1, all 32 locations correct; same-cycle read of the address being written returns the old value.
- srst_n=0 mid-SWEEP at ptr=10 -> outputs reset next edge, locations 10..31 keep old data, wr_ready=1 one cycle after release.
- FB_TEARFREE_EN with visible=1 for 5 cycles during SWEEP -> ptr frozen, no writes; wr_ready=0 while visible; clear completes 5 cycles later than without the macro.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared types for the fb_vram framebuffer.
// Default pixel/address widths and the clear FSM state encoding.
package fb_pkg;

    localparam int FB_PIX_W  = 3;
    localparam int FB_ADDR_W = 20;

    typedef logic [FB_PIX_W-1:0]  pixel_t;
    typedef logic [FB_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWEEP,
        DONE
    } fb_clr_state_e;

endpackage

// File: rtl/fb_wr_addr_pipe.sv
// fb_wr_addr_pipe: 2-stage write pipeline, bounds check in S1,
// linear address y*width+x in S2; valids flushed on reset.
module fb_wr_addr_pipe
    import fb_pkg::*;
#(
    parameter int PIX_W  = FB_PIX_W,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_srst_n,
    input  logic              i_valid,
    input  logic [9:0]        i_x,
    input  logic [9:0]        i_y,
    input  logic [9:0]        i_width,
    input  logic [9:0]        i_height,
    input  logic [PIX_W-1:0]  i_color,
    output logic              o_s1_valid,
    output logic              o_s2_valid,
    output logic              o_s2_inb,
    output logic [ADDR_W-1:0] o_s2_addr,
    output logic [PIX_W-1:0]  o_s2_color
);

    logic              r_s1_valid;
    logic              r_s1_inb;
    logic [9:0]        r_s1_x;
    logic [9:0]        r_s1_y;
    logic [9:0]        r_s1_w;
    logic [PIX_W-1:0]  r_s1_color;
    logic              r_s2_valid;
    logic              r_s2_inb;
    logic [ADDR_W-1:0] r_s2_addr;
    logic [PIX_W-1:0]  r_s2_color;
    logic [ADDR_W-1:0] w_addr;

    // Stride is captured at accept so later width changes leave it alone.
    assign w_addr = ADDR_W'(r_s1_y) * ADDR_W'(r_s1_w) + ADDR_W'(r_s1_x);

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_inb   <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_w     <= '0;
            r_s1_color <= '0;
            r_s2_valid <= 1'b0;
            r_s2_inb   <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_color <= '0;
        end else begin
            r_s1_valid <= i_valid;
            r_s1_inb   <= (i_x < i_width) && (i_y < i_height);
            r_s1_x     <= i_x;
            r_s1_y     <= i_y;
            r_s1_w     <= i_width;
            r_s1_color <= i_color;
            r_s2_valid <= r_s1_valid;
            r_s2_inb   <= r_s1_inb;
            r_s2_addr  <= w_addr;
            r_s2_color <= r_s1_color;
        end
    end

    assign o_s1_valid = r_s1_valid;
    assign o_s2_valid = r_s2_valid;
    assign o_s2_inb   = r_s2_inb;
    assign o_s2_addr  = r_s2_addr;
    assign o_s2_color = r_s2_color;

endmodule

// File: rtl/fb_vram.sv
// fb_vram: single-clock framebuffer with VGA read port, pipelined
// pixel writes and clear sweep. FB_TEARFREE_EN defers updates to blanking.
module fb_vram
    import fb_pkg::*;
#(
    parameter int BUF_WIDTH  = 640,
    parameter int BUF_HEIGHT = 480,
    parameter int PIX_W      = FB_PIX_W,
    parameter int ADDR_W     = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic [9:0]        width,
    input  logic [9:0]        height,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    input  logic              visible,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [9:0]        wr_x,
    input  logic [9:0]        wr_y,
    input  logic [PIX_W-1:0]  wr_color,
    output logic              wr_oob,
    input  logic              clr_req,
    input  logic [PIX_W-1:0]  clr_color,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int N     = BUF_WIDTH * BUF_HEIGHT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_W:0] N_EXT = (ADDR_W+1)'(N);

    logic [PIX_W-1:0]  r_mem [N];
    logic [PIX_W-1:0]  r_rd_data;
    fb_clr_state_e     r_state;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_oob;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_last;
    logic [PIX_W-1:0]  r_clr_color;

    logic              w_acc;
    logic              w_hold;
    logic              w_s1_valid;
    logic              w_s2_valid;
    logic              w_s2_inb;
    logic [ADDR_W-1:0] w_s2_addr;
    logic [PIX_W-1:0]  w_s2_color;
    logic [ADDR_W-1:0] w_area;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [PIX_W-1:0]  w_wdata;
    logic              w_unused;

`ifdef FB_TEARFREE_EN
    assign w_hold   = visible;
    assign wr_ready = r_ready && srst_n && !visible;
`else
    assign w_hold   = 1'b0;
    assign wr_ready = r_ready && srst_n;
`endif

    assign w_acc    = wr_valid && wr_ready;
    assign w_area   = ADDR_W'(width) * ADDR_W'(height);
    assign w_unused = ^{visible, w_waddr, w_s2_addr};

    fb_wr_addr_pipe #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .i_clk      (clk),
        .i_srst_n   (srst_n),
        .i_valid    (w_acc),
        .i_x        (wr_x),
        .i_y        (wr_y),
        .i_width    (width),
        .i_height   (height),
        .i_color    (wr_color),
        .o_s1_valid (w_s1_valid),
        .o_s2_valid (w_s2_valid),
        .o_s2_inb   (w_s2_inb),
        .o_s2_addr  (w_s2_addr),
        .o_s2_color (w_s2_color)
    );

    // Pipeline and sweep never overlap: the sweep starts only once drained.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (w_s2_valid && w_s2_inb) begin
            w_we    = 1'b1;
            w_waddr = w_s2_addr;
            w_wdata = w_s2_color;
        end else if (r_state == SWEEP && !w_hold) begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
            w_wdata = r_clr_color;
        end
    end

    always_ff @(posedge clk) begin
        if (srst_n && w_we) begin
            r_mem[w_waddr[IDX_W-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_rd_data <= '0;
        end else if ({1'b0, rd_addr} < N_EXT) begin
            r_rd_data <= r_mem[rd_addr[IDX_W-1:0]];
        end else begin
            r_rd_data <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_oob       <= 1'b0;
            r_ptr       <= '0;
            r_last      <= '0;
            r_clr_color <= '0;
        end else begin
            r_done <= 1'b0;
            r_oob  <= w_s2_valid && !w_s2_inb;
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (clr_req) begin
                        r_clr_color <= clr_color;
                        r_busy      <= 1'b1;
                        r_ready     <= 1'b0;
                        r_state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!w_s1_valid && !w_s2_valid) begin
                        r_ptr  <= '0;
                        r_last <= w_area - ADDR_W'(1);
                        if (w_area == '0) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= SWEEP;
                        end
                    end
                end
                SWEEP: begin
                    if (!w_hold) begin
                        if (r_ptr == r_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign wr_oob   = r_oob;
    assign clr_busy = r_busy;
    assign clr_done = r_done;

endmodule
